ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative unsigned multiply/divide unit in the EX stage of the 5-stage RISC-V pipeline. It is the consumer of the ID/EX pipeline register's outputs (func3, func7, rd, forwarded rs1/rs2 operands). It executes RV32M MUL, MULHU, DIVU and REMU over 32 iterations. While it runs, it drives a stall back upstream that freezes the PC, IF/ID and ID/EX and bubbles EX/MEM.

## Interface
Parameters: none (datapath fixed at 32 bits, 32 iterations).

Ports (synchronous, active-high reset, single clock):
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous active-high reset
- valid_i  in  1  EX holds a valid R-type instruction (low on bubbles)
- func3_i  in  3  func3 from ID/EX
- func7_i  in  7  func7 from ID/EX
- rd_i  in  5  destination register from ID/EX
- rs1_data_i  in  32  forwarded rs1 operand (multiplicand / dividend)
- rs2_data_i  in  32  forwarded rs2 operand (multiplier / divisor)
- stall_o  out  1  hold PC, IF/ID, ID/EX; insert bubble into EX/MEM
- done_o  out  1  result_o/rd_o valid this cycle; EX/MEM captures result
- result_o  out  32  final result
- rd_o  out  5  destination register of the completed op

## Operation
- Accept condition: `valid_i && func7_i==7'b0000001 && func3_i ∈ {000 MUL, 011 MULHU, 101 DIVU, 111 REMU}` while in IDLE.
- Other func3 values with func7=0000001 (MULH, MULHSU, DIV, REM) are not accepted. stall_o and done_o stay 0. The top level must not issue them.
- States:
  - IDLE
    - on accept: latch operands, op and rd; clear the counter; go to BUSY.
  - BUSY
    - perform one iteration per cycle;
    - after the 32nd iteration, go to DONE.
  - DONE
    - present the result for exactly one cycle, then go to IDLE;
    - inputs are ignored in this state, even though ID/EX still shows the same instruction.
- Multiply: shift-add on a 64-bit accumulator. MUL returns product[31:0]; MULHU returns product[63:32].
- Divide: restoring division, with a 33-bit trial subtraction per iteration. DIVU returns the quotient; REMU returns the remainder.
- Divide by zero (RISC-V semantics, no trap): DIVU = 32'hFFFFFFFF, REMU = rs1 value.
- Counter: 6 bits, counting 0..31. Wrap is not used; BUSY exits when the counter equals 31.
- stall_o is combinational: `(IDLE && accept) || BUSY`. It is 0 in DONE, so the pipeline advances at the end of the DONE cycle.
- result_o and rd_o are registered. They hold their last value outside DONE.
- Reset: state IDLE, counter 0, stall_o 0, done_o 0, result_o 0, rd_o 0, internal accumulators 0.
- Reset mid-operation aborts the operation. The result is discarded and done_o is never raised for it.

## Timing
- Cycle 0 (accept): stall_o=1. Operands are latched at the cycle-0 edge.
- Cycles 1..32: BUSY, stall_o=1. One iteration retires per edge.
- Cycle 33: DONE. done_o=1, stall_o=0, result_o/rd_o valid.
- Total: 34 cycles from EX entry to EX/MEM capture; 33 stall cycles.
- Back-to-back M ops: the second op enters EX at cycle 34 (IDLE) and is accepted in that same cycle. No dead cycle beyond DONE.
- Operands are sampled only in the accept cycle. Forwarding changes during BUSY have no effect.
- Non-M instructions: zero added latency; stall_o=0 throughout.

## Test plan
- MUL: rs1=7, rs2=6.
  - stall_o high for cycles 0..32;
  - cycle 33: done_o=1, result_o=42, rd_o=rd_i;
  - cycle 34: done_o=0.
- MULHU: 0xFFFFFFFF × 0xFFFFFFFF → result_o=0xFFFFFFFE. Same op with MUL → 0x00000001.
- DIVU / REMU:
  - 100/7 → 14 and 2;
  - 0x80000000/1 → 0x80000000 and 0;
  - 5/0 → DIVU=0xFFFFFFFF, REMU=5.
- Back-to-back with non-M ops:
  - MUL followed immediately by DIVU: the second op is accepted at cycle 34 and done at cycle 67;
  - an ADD (func7=0) or a bubble (valid_i=0) never raises stall_o;
  - MULH (func3=001) is not accepted.
- Reset mid-operation: assert rst_i at cycle 10 of a MUL.
  - next cycle: stall_o=0, done_o=0, result_o=0;
  - no done_o pulse follows;
  - a new op accepted afterwards completes correctly.
- DONE ignores inputs: hold valid_i/func7 as a MUL through the DONE cycle → no re-accept in DONE; exactly one done_o pulse.

Source files
------------

// File: rtl/ex_muldiv.sv
// Iterative RV32M unsigned multiply/divide for the EX stage: MUL, MULHU, DIVU, REMU
// over 32 single-bit iterations, stalling the upstream pipeline while it runs.
module ex_muldiv (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [2:0]  func3_i,
  input  logic [6:0]  func7_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [4:0]  rd_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q;
  logic [63:0] acc_q;
  logic [31:0] opb_q;
  logic        is_div_q;
  logic        sel_hi_q;
  logic [4:0]  rd_q;
  logic        accept;
  logic [63:0] acc_step;

  // Shift-add: acc = {partial_hi, multiplier_remaining}; one multiplier bit retired per call.
  function automatic logic [63:0] mul_step(input logic [63:0] acc, input logic [31:0] mcand);
    logic [32:0] sum;
    sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
    return {sum, acc[31:1]};
  endfunction

  // Restoring division: acc = {remainder, dividend/quotient}. A zero divisor naturally
  // yields quotient all-ones and remainder equal to the dividend.
  function automatic logic [63:0] div_step(input logic [63:0] acc, input logic [31:0] dsor);
    logic [32:0] sh;
    logic [31:0] trial;
    sh    = {acc[63:32], acc[31]};
    trial = sh[31:0] - dsor;
    if (sh >= {1'b0, dsor})
      return {trial, acc[30:0], 1'b1};
    else
      return {sh[31:0], acc[30:0], 1'b0};
  endfunction

  // func3[2] selects divide, func3[1] selects the upper half (MULHU / REMU).
  always_comb begin
    accept = valid_i && (func7_i == 7'b0000001) &&
             ((func3_i == 3'b000) || (func3_i == 3'b011) ||
              (func3_i == 3'b101) || (func3_i == 3'b111));
  end

  always_comb begin
    acc_step = is_div_q ? div_step(acc_q, opb_q) : mul_step(acc_q, opb_q);
  end

  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          stall_o = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (cnt_q == 6'd31) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      acc_q    <= 64'd0;
      opb_q    <= 32'd0;
      is_div_q <= 1'b0;
      sel_hi_q <= 1'b0;
      rd_q     <= 5'd0;
      result_o <= 32'd0;
      rd_o     <= 5'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_q    <= 6'd0;
            is_div_q <= func3_i[2];
            sel_hi_q <= func3_i[1];
            rd_q     <= rd_i;
            acc_q    <= {32'd0, func3_i[2] ? rs1_data_i : rs2_data_i};
            opb_q    <= func3_i[2] ? rs2_data_i : rs1_data_i;
          end
        end
        BUSY: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            result_o <= sel_hi_q ? acc_step[63:32] : acc_step[31:0];
            rd_o     <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: expected results queued at issue, popped at done_o.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [2:0]  func3_i;
  logic [6:0]  func7_i;
  logic [4:0]  rd_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .func3_i(func3_i),
    .func7_i(func7_i), .rd_i(rd_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .stall_o(stall_o), .done_o(done_o), .result_o(result_o), .rd_o(rd_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (f3)
      3'b000:  return p[31:0];
      3'b011:  return p[63:32];
      3'b101:  return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Issue one M op at the next cycle (cycle 0) and follow it through DONE (cycle 33).
  // Operands and rd are scrambled after acceptance; the op encoding stays on the
  // inputs through DONE so a re-accept there would be visible on the next cycle.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   bad;
    @(posedge clk); #1;
    valid_i = 1'b1; func7_i = 7'b0000001; func3_i = f3;
    rd_i = rd; rs1_data_i = a; rs2_data_i = b;
    #1;
    chk({tag, "_stall_c0"}, 32'(stall_o), 32'd1);
    e.res = model(f3, a, b);
    e.rd  = rd;
    sb.push_back(e);
    bad = 0;
    for (int cyc = 1; cyc <= 32; cyc++) begin
      @(posedge clk); #1;
      rs1_data_i = $urandom;
      rs2_data_i = $urandom;
      rd_i       = 5'($urandom);
      #1;
      if (stall_o !== 1'b1 || done_o !== 1'b0) bad++;
    end
    chk({tag, "_busy_cycles_bad"}, 32'(bad), 32'd0);
    @(posedge clk); #1; #1;
    chk({tag, "_done_c33"}, 32'(done_o), 32'd1);
    chk({tag, "_stall_c33"}, 32'(stall_o), 32'd0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_result"}, result_o, e.res);
      chk({tag, "_rd"}, 32'(rd_o), 32'(e.rd));
    end
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk); #1;
    valid_i = 1'b0; func7_i = 7'd0; func3_i = 3'd0;
    #1;
    chk({tag, "_idle_stall"}, 32'(stall_o), 32'd0);
    chk({tag, "_idle_done"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    int bad;
    logic [31:0] last;
    rst_i = 1'b1; valid_i = 1'b0; func3_i = 3'd0; func7_i = 7'd0;
    rd_i = 5'd0; rs1_data_i = 32'd0; rs2_data_i = 32'd0;
    repeat (2) @(posedge clk);
    #1; rst_i = 1'b0; #1;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_rd", 32'(rd_o), 32'd0);

    run_op("mul_7x6", 3'b000, 5'd5, 32'd7, 32'd6);
    idle_cycle("mul_7x6_c34");
    chk("mul_hold_result", result_o, 32'd42);
    chk("mul_hold_rd", 32'(rd_o), 32'd5);

    run_op("mulhu_max", 3'b011, 5'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mul_max", 3'b000, 5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("divu_100_7", 3'b101, 5'd11, 32'd100, 32'd7);
    run_op("remu_100_7", 3'b111, 5'd12, 32'd100, 32'd7);
    run_op("divu_msb_1", 3'b101, 5'd13, 32'h8000_0000, 32'd1);
    run_op("remu_msb_1", 3'b111, 5'd14, 32'h8000_0000, 32'd1);
    run_op("divu_5_0", 3'b101, 5'd15, 32'd5, 32'd0);
    run_op("remu_5_0", 3'b111, 5'd16, 32'd5, 32'd0);
    idle_cycle("divzero");

    // Back-to-back: DIVU accepted at cycle 34, done at cycle 67.
    run_op("b2b_mul", 3'b000, 5'd17, 32'd123456, 32'd789);
    run_op("b2b_divu", 3'b101, 5'd18, 32'hDEAD_BEEF, 32'd1234);
    idle_cycle("b2b");

    // Non-M traffic: ADD, bubble carrying M encoding, MULH.
    @(posedge clk); #1;
    valid_i = 1'b1; func7_i = 7'd0; func3_i = 3'b000; #1;
    chk("add_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    valid_i = 1'b0; func7_i = 7'b0000001; func3_i = 3'b000; #1;
    chk("bubble_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    valid_i = 1'b1; func7_i = 7'b0000001; func3_i = 3'b001; #1;
    chk("mulh_stall", 32'(stall_o), 32'd0);
    idle_cycle("after_mulh");

    for (int i = 0; i < 4; i++) begin
      logic [2:0] f3;
      case (i)
        0: f3 = 3'b000;
        1: f3 = 3'b011;
        2: f3 = 3'b101;
        default: f3 = 3'b111;
      endcase
      run_op($sformatf("rand%0d", i), f3, 5'(i + 20), $urandom, 32'($urandom_range(1, 65535)));
    end
    idle_cycle("rand");

    // Reset at cycle 10 of a MUL aborts it.
    last = result_o;
    chk("pre_reset_result_nonzero", 32'(last != 32'd0), 32'd1);
    @(posedge clk); #1;
    valid_i = 1'b1; func7_i = 7'b0000001; func3_i = 3'b000;
    rd_i = 5'd3; rs1_data_i = 32'd1000; rs2_data_i = 32'd1000;
    repeat (9) @(posedge clk);
    #1; valid_i = 1'b0; func7_i = 7'd0; rst_i = 1'b1;
    @(posedge clk); #1; rst_i = 1'b0; #1;
    chk("abort_stall", 32'(stall_o), 32'd0);
    chk("abort_done", 32'(done_o), 32'd0);
    chk("abort_result", result_o, 32'd0);
    chk("abort_rd", 32'(rd_o), 32'd0);
    bad = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      if (done_o !== 1'b0 || stall_o !== 1'b0) bad++;
    end
    chk("abort_no_done", 32'(bad), 32'd0);

    run_op("post_reset_mul", 3'b000, 5'd31, 32'h0001_0001, 32'h0000_FFFF);
    idle_cycle("end");
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
